// File: rtl/random_position_gen_if.sv
// -----------------------------------------------------------------------------
// random_position_gen_if
//
// Purpose : valid/ready channel that carries one (x, y) spawn coordinate pair
//           from random_position_gen to the game-state logic.
//
// Signals : pos_x     - x coordinate, COORD_W bits  (producer -> consumer)
//           pos_y     - y coordinate, COORD_W bits  (producer -> consumer)
//           pos_valid - coordinate pair valid        (producer -> consumer)
//           pos_ready - consumer accepts the pair    (consumer -> producer)
//
// Modports: master - coordinate producer
//           slave  - coordinate consumer
// -----------------------------------------------------------------------------
interface random_position_gen_if #(
    parameter int unsigned COORD_W = 10
);
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               pos_valid;
    logic               pos_ready;

    modport master (
        output pos_x,
        output pos_y,
        output pos_valid,
        input  pos_ready
    );

    modport slave (
        input  pos_x,
        input  pos_y,
        input  pos_valid,
        output pos_ready
    );
endinterface

// File: rtl/random_position_gen.sv
// -----------------------------------------------------------------------------
// random_position_gen
//
// Purpose : builds one uniformly distributed (x, y) spawn coordinate pair per
//           start request. It steps the upstream LFSR stage once per draw and
//           uses rejection sampling on a power-of-two mask of the draw, so the
//           result is not skewed by clamping. After MAX_TRIES rejected draws on
//           one axis it folds the last draw back into range instead of
//           retrying forever, which bounds the latency.
//
// Ports   : clk        - system clock, all state on the rising edge
//           reset      - asynchronous, active-low reset
//           start      - request a new pair (level, sampled each edge)
//           rng_enable - one-cycle step strobe to the LFSR stage
//           rng_max    - constant all-ones, disables clamping in the LFSR stage
//           rng_value  - current LFSR output
//           busy       - high in every state except IDLE
//           pos_if     - coordinate valid/ready channel (master side)
// -----------------------------------------------------------------------------
module random_position_gen #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_RANGE   = 640,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_RANGE   = 480,
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rng_enable,
    output logic [31:0]           rng_max,
    input  logic [31:0]           rng_value,
    output logic                  busy,
    random_position_gen_if.master pos_if
);

    // Smallest 2^k-1 that covers range-1; a masked draw is then uniform over
    // 0..mask and rejecting values >= range keeps the accepted ones uniform.
    function automatic int unsigned mask_for(input int unsigned range);
        int unsigned m;
        m = 0;
        for (int i = 0; i < 32; i++) begin
            if (m < range - 1) begin
                m = (m << 1) | 32'd1;
            end
        end
        return m;
    endfunction

    localparam logic [COORD_W-1:0] MASK_X    = COORD_W'(mask_for(X_RANGE));
    localparam logic [COORD_W-1:0] MASK_Y    = COORD_W'(mask_for(Y_RANGE));
    localparam logic [COORD_W-1:0] X_MIN_W   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] Y_MIN_W   = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] X_RANGE_W = COORD_W'(X_RANGE);
    localparam logic [COORD_W-1:0] Y_RANGE_W = COORD_W'(Y_RANGE);

    typedef enum logic [2:0] {
        IDLE,
        REQ_X,
        WAIT_X,
        REQ_Y,
        WAIT_Y,
        OUT
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         tries_q, tries_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;

    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic               cand_x_ok;
    logic               cand_y_ok;
    logic               retry_ok;

    // Only the coordinate fields of the draw are consumed.
    logic unused_rng_bits;
    assign unused_rng_bits = ^rng_value;

    assign cand_x    = rng_value[COORD_W-1:0] & MASK_X;
    assign cand_y    = rng_value[COORD_W+15:16] & MASK_Y;
    // Compared at 32 bits so a range of exactly 2^COORD_W never truncates.
    assign cand_x_ok = (32'(cand_x) < X_RANGE);
    assign cand_y_ok = (32'(cand_y) < Y_RANGE);
    assign retry_ok  = ((32'(tries_q) + 32'd1) < MAX_TRIES);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tries_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ_X;
                    tries_d = '0;
                end
            end

            REQ_X: state_d = WAIT_X;

            WAIT_X: begin
                if (cand_x_ok) begin
                    pos_x_d = X_MIN_W + cand_x;
                    tries_d = '0;
                    state_d = REQ_Y;
                end else if (retry_ok) begin
                    tries_d = tries_q + 4'd1;
                    state_d = REQ_X;
                end else begin
                    // cand_x <= MASK_X < 2*X_RANGE, so the fold lands in range.
                    pos_x_d = X_MIN_W + (cand_x - X_RANGE_W);
                    tries_d = '0;
                    state_d = REQ_Y;
                end
            end

            REQ_Y: state_d = WAIT_Y;

            WAIT_Y: begin
                if (cand_y_ok) begin
                    pos_y_d = Y_MIN_W + cand_y;
                    tries_d = '0;
                    state_d = OUT;
                end else if (retry_ok) begin
                    tries_d = tries_q + 4'd1;
                    state_d = REQ_Y;
                end else begin
                    pos_y_d = Y_MIN_W + (cand_y - Y_RANGE_W);
                    tries_d = '0;
                    state_d = OUT;
                end
            end

            OUT: begin
                // A start in the handshake cycle chains straight into the next
                // draw; any other start while busy is dropped.
                if (pos_if.pos_ready) begin
                    if (start) begin
                        state_d = REQ_X;
                        tries_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only, so reset clears them at once.
    // REQ states are always followed by a WAIT state, so the strobe can never
    // be high in two consecutive cycles.
    assign rng_enable       = (state_q == REQ_X) || (state_q == REQ_Y);
    assign rng_max          = 32'hFFFF_FFFF;
    assign busy             = (state_q != IDLE);
    assign pos_if.pos_valid = (state_q == OUT);
    assign pos_if.pos_x     = pos_x_q;
    assign pos_if.pos_y     = pos_y_q;

endmodule

// File: tb/tb_random_position_gen.sv
// -----------------------------------------------------------------------------
// tb_random_position_gen
//
// Purpose : directed bench for random_position_gen. A stub feeds queued draws
//           to the default-parameter instance, advancing on each rng_enable
//           edge; a second instance with offset ranges is driven by a real
//           32-bit Galois LFSR for a long range/strobe run.
// -----------------------------------------------------------------------------
module tb_random_position_gen;

    localparam int COORD_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- directed instance (default parameters) ----------------
    logic               d_start;
    logic               d_rng_enable;
    logic [31:0]        d_rng_max;
    logic [31:0]        d_rng_value = '0;
    logic               d_busy;
    logic [31:0]        stub_q[$];

    random_position_gen_if #(.COORD_W(COORD_W)) d_if ();

    random_position_gen #(.COORD_W(COORD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (d_start),
        .rng_enable (d_rng_enable),
        .rng_max    (d_rng_max),
        .rng_value  (d_rng_value),
        .busy       (d_busy),
        .pos_if     (d_if)
    );

    // Stub LFSR stage: presents the next queued draw after each step strobe.
    always @(posedge clk) begin
        if (d_rng_enable && stub_q.size() != 0) begin
            d_rng_value <= stub_q.pop_front();
        end
    end

    // ---------------- random instance with a real LFSR ----------------
    logic               r_start;
    logic               r_rng_enable;
    logic [31:0]        r_rng_max;
    logic [31:0]        lfsr_q = 32'hACE1_2345;
    logic               r_busy;

    random_position_gen_if #(.COORD_W(COORD_W)) r_if ();

    random_position_gen #(
        .COORD_W (COORD_W),
        .X_MIN   (16),
        .X_RANGE (600),
        .Y_MIN   (8),
        .Y_RANGE (400)
    ) dut_rand (
        .clk        (clk),
        .reset      (reset),
        .start      (r_start),
        .rng_enable (r_rng_enable),
        .rng_max    (r_rng_max),
        .rng_value  (lfsr_q),
        .busy       (r_busy),
        .pos_if     (r_if)
    );

    always @(posedge clk) begin
        if (r_rng_enable) begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Hand the pending pair over and return to IDLE.
    task automatic drain();
        d_if.pos_ready = 1'b1;
        step();
        d_if.pos_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset          = 1'b0;
        d_start        = 1'b0;
        d_if.pos_ready = 1'b0;
        r_start        = 1'b0;
        r_if.pos_ready = 1'b0;
        step();
        step();
        n_checks++; if (d_rng_enable !== 1'b0) $display("FAIL reset_rng_enable got %b want 0", d_rng_enable); else n_pass++;
        n_checks++; if (d_if.pos_valid !== 1'b0) $display("FAIL reset_pos_valid got %b want 0", d_if.pos_valid); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", d_busy); else n_pass++;
        n_checks++; if (d_if.pos_x !== 10'd0) $display("FAIL reset_pos_x got %0d want 0", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd0) $display("FAIL reset_pos_y got %0d want 0", d_if.pos_y); else n_pass++;
        n_checks++; if (d_rng_max !== 32'hFFFF_FFFF) $display("FAIL reset_rng_max got %h want ffffffff", d_rng_max); else n_pass++;
        reset = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic();
        logic [15:0] en_exp;
        en_exp = 16'b0000_0000_0000_1010;
        stub_q = {32'h00C8_0123, 32'h00C8_0123};
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            n_checks++; if (d_rng_enable !== en_exp[k]) $display("FAIL basic_rng_enable c%0d got %b want %b", k, d_rng_enable, en_exp[k]); else n_pass++;
            n_checks++; if (d_if.pos_valid !== (k >= 5)) $display("FAIL basic_pos_valid c%0d got %b want %b", k, d_if.pos_valid, (k >= 5)); else n_pass++;
            if (k == 5) begin
                n_checks++; if (d_if.pos_x !== 10'd291) $display("FAIL basic_pos_x got %0d want 291", d_if.pos_x); else n_pass++;
                n_checks++; if (d_if.pos_y !== 10'd200) $display("FAIL basic_pos_y got %0d want 200", d_if.pos_y); else n_pass++;
            end
            if (k < 6) step();
        end
        drain();
        n_checks++; if (d_if.pos_valid !== 1'b0) $display("FAIL basic_after_hs_valid got %b want 0", d_if.pos_valid); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL basic_after_hs_busy got %b want 0", d_busy); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_rejection();
        logic [15:0] en_exp;
        en_exp = 16'b0000_0000_0010_1010;
        stub_q = {32'h0000_03FF, 32'h0000_0010, 32'h0064_0000};
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            n_checks++; if (d_rng_enable !== en_exp[k]) $display("FAIL reject_rng_enable c%0d got %b want %b", k, d_rng_enable, en_exp[k]); else n_pass++;
            n_checks++; if (d_if.pos_valid !== (k == 7)) $display("FAIL reject_pos_valid c%0d got %b want %b", k, d_if.pos_valid, (k == 7)); else n_pass++;
            if (k < 7) step();
        end
        n_checks++; if (d_if.pos_x !== 10'd16) $display("FAIL reject_pos_x got %0d want 16", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd100) $display("FAIL reject_pos_y got %0d want 100", d_if.pos_y); else n_pass++;
        drain();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fallback();
        logic [15:0] en_exp;
        en_exp = 16'b0000_0010_1010_1010;
        stub_q = {32'h0000_03FF, 32'h0000_03FF, 32'h0000_03FF, 32'h0000_03FF, 32'h0064_0000};
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            n_checks++; if (d_rng_enable !== en_exp[k]) $display("FAIL fallback_rng_enable c%0d got %b want %b", k, d_rng_enable, en_exp[k]); else n_pass++;
            n_checks++; if (d_if.pos_valid !== (k == 11)) $display("FAIL fallback_pos_valid c%0d got %b want %b", k, d_if.pos_valid, (k == 11)); else n_pass++;
            if (k < 11) step();
        end
        n_checks++; if (d_if.pos_x !== 10'd383) $display("FAIL fallback_pos_x got %0d want 383", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd100) $display("FAIL fallback_pos_y got %0d want 100", d_if.pos_y); else n_pass++;
        drain();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        stub_q = {32'h0001_0002, 32'h0001_0002};
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            d_start = (i != 1);
            step();
            n_checks++; if (d_if.pos_valid !== 1'b1) $display("FAIL bp_pos_valid i%0d got %b want 1", i, d_if.pos_valid); else n_pass++;
            n_checks++; if (d_if.pos_x !== 10'd2) $display("FAIL bp_pos_x i%0d got %0d want 2", i, d_if.pos_x); else n_pass++;
            n_checks++; if (d_if.pos_y !== 10'd1) $display("FAIL bp_pos_y i%0d got %0d want 1", i, d_if.pos_y); else n_pass++;
            n_checks++; if (d_rng_enable !== 1'b0) $display("FAIL bp_rng_enable i%0d got %b want 0", i, d_rng_enable); else n_pass++;
        end
        d_start = 1'b0;
        drain();
        n_checks++; if (d_if.pos_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", d_if.pos_valid); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL bp_release_busy got %b want 0", d_busy); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        stub_q = {32'h0001_0002, 32'h0001_0002, 32'h0007_0005, 32'h0007_0005};
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (4) step();
        n_checks++; if (d_if.pos_valid !== 1'b1) $display("FAIL b2b_first_valid got %b want 1", d_if.pos_valid); else n_pass++;
        d_start        = 1'b1;
        d_if.pos_ready = 1'b1;
        step();
        d_start        = 1'b0;
        d_if.pos_ready = 1'b0;
        n_checks++; if (d_if.pos_valid !== 1'b0) $display("FAIL b2b_valid_drop got %b want 0", d_if.pos_valid); else n_pass++;
        n_checks++; if (d_rng_enable !== 1'b1) $display("FAIL b2b_rng_enable got %b want 1", d_rng_enable); else n_pass++;
        for (int k = 2; k <= 5; k++) begin
            step();
            n_checks++; if (d_if.pos_valid !== (k == 5)) $display("FAIL b2b_pos_valid c%0d got %b want %b", k, d_if.pos_valid, (k == 5)); else n_pass++;
        end
        n_checks++; if (d_if.pos_x !== 10'd5) $display("FAIL b2b_pos_x got %0d want 5", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd7) $display("FAIL b2b_pos_y got %0d want 7", d_if.pos_y); else n_pass++;
        drain();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_draw();
        logic [15:0] en_exp;
        en_exp = 16'b0000_0000_0000_1010;
        stub_q = {32'h0001_0002, 32'h0001_0002, 32'h0003_0004, 32'h0003_0004};
        d_start = 1'b1;
        repeat (4) step();
        // Now in WAIT_Y with pos_x already latched; drop reset mid-cycle.
        #2 reset = 1'b0;
        #1;
        n_checks++; if (d_rng_enable !== 1'b0) $display("FAIL midrst_rng_enable got %b want 0", d_rng_enable); else n_pass++;
        n_checks++; if (d_if.pos_valid !== 1'b0) $display("FAIL midrst_pos_valid got %b want 0", d_if.pos_valid); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", d_busy); else n_pass++;
        n_checks++; if (d_if.pos_x !== 10'd0) $display("FAIL midrst_pos_x got %0d want 0", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd0) $display("FAIL midrst_pos_y got %0d want 0", d_if.pos_y); else n_pass++;
        n_checks++; if (d_rng_max !== 32'hFFFF_FFFF) $display("FAIL midrst_rng_max got %h want ffffffff", d_rng_max); else n_pass++;
        step();
        reset = 1'b1;
        step();
        d_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_checks++; if (d_rng_enable !== en_exp[k]) $display("FAIL midrst_gen_rng_enable c%0d got %b want %b", k, d_rng_enable, en_exp[k]); else n_pass++;
            n_checks++; if (d_if.pos_valid !== (k == 5)) $display("FAIL midrst_gen_valid c%0d got %b want %b", k, d_if.pos_valid, (k == 5)); else n_pass++;
            if (k < 5) step();
        end
        n_checks++; if (d_if.pos_x !== 10'd4) $display("FAIL midrst_gen_pos_x got %0d want 4", d_if.pos_x); else n_pass++;
        n_checks++; if (d_if.pos_y !== 10'd3) $display("FAIL midrst_gen_pos_y got %0d want 3", d_if.pos_y); else n_pass++;
        drain();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int   pairs;
        int   cyc;
        int   viol;
        logic prev_en;
        pairs          = 0;
        cyc            = 0;
        viol           = 0;
        prev_en        = 1'b0;
        r_start        = 1'b1;
        r_if.pos_ready = 1'b1;
        while (pairs < 2000 && cyc < 40000) begin
            step();
            cyc++;
            if (r_rng_enable && prev_en) viol++;
            prev_en = r_rng_enable;
            if (r_if.pos_valid) begin
                pairs++;
                n_checks++;
                if (r_if.pos_x < 10'd16 || r_if.pos_x >= 10'd616 || r_if.pos_y < 10'd8 || r_if.pos_y >= 10'd408)
                    $display("FAIL random_range pair %0d got x=%0d y=%0d want x in 16..615 y in 8..407", pairs, r_if.pos_x, r_if.pos_y);
                else
                    n_pass++;
            end
        end
        r_start        = 1'b0;
        r_if.pos_ready = 1'b0;
        n_checks++; if (pairs != 2000) $display("FAIL random_pair_count got %0d want 2000 within budget", pairs); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL random_consecutive_strobe got %0d want 0", viol); else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rejection();
        test_fallback();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_draw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
